// File: rtl/mcu_arbiter.sv
// mcu_arbiter: round-robin arbiter sharing one MCU among NUM_CORES warp requesters.
// The granted core's request set goes to the MCU as a one-cycle pulse. Once the MCU
// is idle again, per-lane ready strobes and the read data go back to that core.
module mcu_arbiter #(
  parameter int NUM_CORES        = 4,
  parameter int THREADS_PER_WARP = 16,
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 32,
  localparam int GW              = $clog2(NUM_CORES)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_CORES-1:0][THREADS_PER_WARP:0] core_read_valid_i,
  input  logic [ADDR_W-1:0]                        core_read_address_i  [NUM_CORES][THREADS_PER_WARP+1],
  input  logic [NUM_CORES-1:0][THREADS_PER_WARP:0] core_write_valid_i,
  input  logic [ADDR_W-1:0]                        core_write_address_i [NUM_CORES][THREADS_PER_WARP+1],
  input  logic [DATA_W-1:0]                        core_write_data_i    [NUM_CORES][THREADS_PER_WARP+1],
  output logic [NUM_CORES-1:0][THREADS_PER_WARP:0] core_read_ready_o,
  output logic [NUM_CORES-1:0][THREADS_PER_WARP:0] core_write_ready_o,
  output logic [DATA_W-1:0]                        core_read_data_o     [THREADS_PER_WARP+1],
  output logic [THREADS_PER_WARP:0]                mcu_read_valid_o,
  output logic [ADDR_W-1:0]                        mcu_read_address_o   [THREADS_PER_WARP+1],
  output logic [THREADS_PER_WARP:0]                mcu_write_valid_o,
  output logic [ADDR_W-1:0]                        mcu_write_address_o  [THREADS_PER_WARP+1],
  output logic [DATA_W-1:0]                        mcu_write_data_o     [THREADS_PER_WARP+1],
  input  logic [DATA_W-1:0]                        mcu_read_data_i      [THREADS_PER_WARP+1],
  input  logic                                     mcu_is_busy_i,
  output logic                                     arb_busy_o,
  output logic [GW-1:0]                            arb_grant_id_o
);

  localparam int LANES = THREADS_PER_WARP + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESPOND   = 2'd3
  } state_t;

  state_t                                  state_q;
  logic [GW-1:0]                           grant_q;
  logic [GW-1:0]                           last_grant_q;
  logic [THREADS_PER_WARP:0]               rd_mask_q;
  logic [THREADS_PER_WARP:0]               wr_mask_q;
  logic                                    first_q;
  logic [THREADS_PER_WARP:0]               mcu_read_valid_q;
  logic [THREADS_PER_WARP:0]               mcu_write_valid_q;
  logic [ADDR_W-1:0]                       mcu_read_address_q  [LANES];
  logic [ADDR_W-1:0]                       mcu_write_address_q [LANES];
  logic [DATA_W-1:0]                       mcu_write_data_q    [LANES];
  logic [NUM_CORES-1:0][THREADS_PER_WARP:0] core_read_ready_q;
  logic [NUM_CORES-1:0][THREADS_PER_WARP:0] core_write_ready_q;
  logic [DATA_W-1:0]                       core_read_data_q    [LANES];

  logic [NUM_CORES-1:0] core_req;
  logic [GW-1:0]        grant_d;
  logic                 grant_valid_d;
  logic [GW-1:0]        cand;

  // A core is requesting when any of its read or write lanes is valid.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_req
    assign core_req[gi] = (|core_read_valid_i[gi]) | (|core_write_valid_i[gi]);
  end

  // Round-robin pick: first requester after the last grant, wrapping modulo NUM_CORES.
  always_comb begin
    grant_valid_d = 1'b0;
    grant_d       = '0;
    cand          = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_CORES);
      if (!grant_valid_d && core_req[cand]) begin
        grant_valid_d = 1'b1;
        grant_d       = cand;
      end
    end
  end

  // Arbitration FSM; every output it drives is a register updated on the state edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      grant_q            <= '0;
      last_grant_q       <= GW'(NUM_CORES - 1);
      rd_mask_q          <= '0;
      wr_mask_q          <= '0;
      first_q            <= 1'b0;
      mcu_read_valid_q   <= '0;
      mcu_write_valid_q  <= '0;
      core_read_ready_q  <= '0;
      core_write_ready_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        mcu_read_address_q[l]  <= '0;
        mcu_write_address_q[l] <= '0;
        mcu_write_data_q[l]    <= '0;
        core_read_data_q[l]    <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid_d && !mcu_is_busy_i) begin
            state_q           <= S_LAUNCH;
            grant_q           <= grant_d;
            rd_mask_q         <= core_read_valid_i[grant_d];
            wr_mask_q         <= core_write_valid_i[grant_d];
            // The launch pulse is loaded here so it appears during LAUNCH.
            mcu_read_valid_q  <= core_read_valid_i[grant_d];
            mcu_write_valid_q <= core_write_valid_i[grant_d];
            for (int l = 0; l < LANES; l++) begin
              mcu_read_address_q[l]  <= core_read_address_i[grant_d][l];
              mcu_write_address_q[l] <= core_write_address_i[grant_d][l];
              mcu_write_data_q[l]    <= core_write_data_i[grant_d][l];
            end
          end
        end
        S_LAUNCH: begin
          state_q           <= S_WAIT_DONE;
          last_grant_q      <= grant_q;
          first_q           <= 1'b1;
          mcu_read_valid_q  <= '0;
          mcu_write_valid_q <= '0;
          for (int l = 0; l < LANES; l++) begin
            mcu_read_address_q[l]  <= '0;
            mcu_write_address_q[l] <= '0;
            mcu_write_data_q[l]    <= '0;
          end
        end
        S_WAIT_DONE: begin
          // The MCU raises busy a cycle late, so its level in the first cycle is ignored.
          first_q <= 1'b0;
          if (!first_q && !mcu_is_busy_i) begin
            state_q                     <= S_RESPOND;
            core_read_ready_q[grant_q]  <= rd_mask_q;
            core_write_ready_q[grant_q] <= wr_mask_q;
            for (int l = 0; l < LANES; l++) begin
              core_read_data_q[l] <= mcu_read_data_i[l];
            end
          end
        end
        S_RESPOND: begin
          state_q            <= S_IDLE;
          core_read_ready_q  <= '0;
          core_write_ready_q <= '0;
          rd_mask_q          <= '0;
          wr_mask_q          <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arb_busy_o          = (state_q != S_IDLE);
  assign arb_grant_id_o      = grant_q;
  assign mcu_read_valid_o    = mcu_read_valid_q;
  assign mcu_write_valid_o   = mcu_write_valid_q;
  assign mcu_read_address_o  = mcu_read_address_q;
  assign mcu_write_address_o = mcu_write_address_q;
  assign mcu_write_data_o    = mcu_write_data_q;
  assign core_read_ready_o   = core_read_ready_q;
  assign core_write_ready_o  = core_write_ready_q;
  assign core_read_data_o    = core_read_data_q;

endmodule

// File: tb/tb_mcu_arbiter.sv
// tb_mcu_arbiter: scenario tasks against a small MCU responder model, with a
// queue of expected transactions pushed at stimulus time and popped on response.
module tb_mcu_arbiter;

  localparam int NC      = 4;
  localparam int T       = 16;
  localparam int L       = T + 1;
  localparam int SERVICE = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [NC-1:0][T:0] core_read_valid = '0;
  logic [NC-1:0][T:0] core_write_valid = '0;
  logic [31:0] core_read_address  [NC][L];
  logic [31:0] core_write_address [NC][L];
  logic [31:0] core_write_data    [NC][L];
  logic [NC-1:0][T:0] core_read_ready;
  logic [NC-1:0][T:0] core_write_ready;
  logic [31:0] core_read_data [L];
  logic [T:0]  mcu_read_valid;
  logic [31:0] mcu_read_address [L];
  logic [T:0]  mcu_write_valid;
  logic [31:0] mcu_write_address [L];
  logic [31:0] mcu_write_data [L];
  logic [31:0] mcu_read_data [L];
  logic        mcu_is_busy;
  logic        arb_busy;
  logic [1:0]  arb_grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int                 core;
    logic [T:0]         rmask;
    logic [T:0]         wmask;
    logic [L-1:0][31:0] addr;
    logic [L-1:0][31:0] wdata;
    logic [L-1:0][31:0] rdata;
  } exp_t;

  typedef struct {
    bit                 launched;
    bit                 responded;
    int                 lat;
    int                 gap;
    int                 gid;
    logic               busy_at_launch;
    logic [T:0]         mrv;
    logic [T:0]         mwv;
    logic [L-1:0][31:0] mra;
    logic [L-1:0][31:0] mwa;
    logic [L-1:0][31:0] mwd;
    bit                 pulse_ok;
    logic [NC-1:0][T:0] crr;
    logic [NC-1:0][T:0] cwr;
    logic [L-1:0][31:0] crd;
    bit                 strobe_ok;
  } obs_t;

  exp_t exp_q[$];

  mcu_arbiter #(.NUM_CORES(NC), .THREADS_PER_WARP(T)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .core_read_valid_i    (core_read_valid),
    .core_read_address_i  (core_read_address),
    .core_write_valid_i   (core_write_valid),
    .core_write_address_i (core_write_address),
    .core_write_data_i    (core_write_data),
    .core_read_ready_o    (core_read_ready),
    .core_write_ready_o   (core_write_ready),
    .core_read_data_o     (core_read_data),
    .mcu_read_valid_o     (mcu_read_valid),
    .mcu_read_address_o   (mcu_read_address),
    .mcu_write_valid_o    (mcu_write_valid),
    .mcu_write_address_o  (mcu_write_address),
    .mcu_write_data_o     (mcu_write_data),
    .mcu_read_data_i      (mcu_read_data),
    .mcu_is_busy_i        (mcu_is_busy),
    .arb_busy_o           (arb_busy),
    .arb_grant_id_o       (arb_grant_id)
  );

  always #5 clk = ~clk;

  // MCU model: busy rises one cycle after the launch pulse and stays up SERVICE cycles.
  // Read data for a lane is its address plus 0x80, held until the next launch.
  logic pend;
  int   cnt;
  logic ext_busy = 1'b0;
  logic [31:0] model_rdata [L];
  assign mcu_is_busy   = (cnt != 0) || ext_busy;
  assign mcu_read_data = model_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
      cnt  <= 0;
      for (int l = 0; l < L; l++) model_rdata[l] <= '0;
    end else begin
      pend <= (mcu_read_valid != '0) || (mcu_write_valid != '0);
      if (pend) cnt <= SERVICE;
      else if (cnt != 0) cnt <= cnt - 1;
      for (int l = 0; l < L; l++)
        if (mcu_read_valid[l]) model_rdata[l] <= mcu_read_address[l] + 32'h80;
    end
  end

  function automatic exp_t make_exp(input int c, input logic [T:0] rm, input logic [T:0] wm,
                                    input logic [31:0] abase, input logic [31:0] dbase);
    exp_t e;
    e.core  = c;
    e.rmask = rm;
    e.wmask = wm;
    for (int l = 0; l < L; l++) begin
      e.addr[l]  = abase + 32'(l);
      e.wdata[l] = dbase + 32'(l);
      e.rdata[l] = abase + 32'(l) + 32'h80;
    end
    return e;
  endfunction

  task automatic post_req(input exp_t e);
    core_read_valid[e.core]  = e.rmask;
    core_write_valid[e.core] = e.wmask;
    for (int l = 0; l < L; l++) begin
      core_read_address[e.core][l]  = e.addr[l];
      core_write_address[e.core][l] = e.addr[l];
      core_write_data[e.core][l]    = e.wdata[l];
    end
  endtask

  // Waits for one launch and its response; the responding core drops its request on the strobe.
  task automatic observe(input bit drop, output obs_t o);
    o.launched = 0; o.responded = 0; o.pulse_ok = 0; o.strobe_ok = 0;
    o.lat = 0; o.gap = 0; o.gid = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (mcu_read_valid != '0 || mcu_write_valid != '0) begin
        o.launched = 1; o.lat = i; break;
      end
    end
    if (!o.launched) return;
    o.gid = int'(arb_grant_id);
    o.busy_at_launch = arb_busy;
    o.mrv = mcu_read_valid;
    o.mwv = mcu_write_valid;
    for (int l = 0; l < L; l++) begin
      o.mra[l] = mcu_read_address[l];
      o.mwa[l] = mcu_write_address[l];
      o.mwd[l] = mcu_write_data[l];
    end
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) o.pulse_ok = (mcu_read_valid == '0) && (mcu_write_valid == '0);
      if (core_read_ready != '0 || core_write_ready != '0) begin
        o.responded = 1; o.gap = i; break;
      end
    end
    if (!o.responded) return;
    o.crr = core_read_ready;
    o.cwr = core_write_ready;
    for (int l = 0; l < L; l++) o.crd[l] = core_read_data[l];
    if (drop)
      for (int c = 0; c < NC; c++)
        if (o.crr[c] != '0 || o.cwr[c] != '0) begin
          core_read_valid[c]  = '0;
          core_write_valid[c] = '0;
        end
    @(negedge clk);
    o.strobe_ok = (core_read_ready == '0) && (core_write_ready == '0);
  endtask

  task automatic test_reset();
    int busy_cycles;
    reset_n = 1'b0;
    core_read_valid[1] = 17'h1;
    @(negedge clk);
    #1;
    n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset arb_busy: got %b want 0", arb_busy); end
    n_checks++; if (arb_grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant: got %0d want 0", arb_grant_id); end
    n_checks++; if (mcu_read_valid !== '0 || mcu_write_valid !== '0) begin n_fail++; $display("FAIL reset mcu_valid: got %h/%h want 0", mcu_read_valid, mcu_write_valid); end
    n_checks++; if (core_read_ready !== '0 || core_write_ready !== '0) begin n_fail++; $display("FAIL reset ready: got %h/%h want 0", core_read_ready, core_write_ready); end
    n_checks++; if (core_read_data[0] !== 32'h0 || mcu_write_data[16] !== 32'h0) begin n_fail++; $display("FAIL reset data: got %h/%h want 0", core_read_data[0], mcu_write_data[16]); end
    core_read_valid[1] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    busy_cycles = 0;
    repeat (5) begin
      @(negedge clk);
      if (arb_busy !== 1'b0 || mcu_read_valid !== '0) busy_cycles++;
    end
    n_checks++; if (busy_cycles != 0) begin n_fail++; $display("FAIL reset idle_after_release: got %0d busy cycles want 0", busy_cycles); end
  endtask

  task automatic test_single_write();
    exp_t e; obs_t o; logic [NC-1:0][T:0] xw;
    // lane 16: address 0x10, data 0xDEAD
    e = make_exp(2, '0, 17'h10000, 32'h10 - 32'd16, 32'hDEAD - 32'd16);
    post_req(e); exp_q.push_back(e);
    observe(1'b1, o);
    e = exp_q.pop_front();
    xw = '0; xw[e.core] = e.wmask;
    n_checks++; if (!o.launched || o.lat != 1) begin n_fail++; $display("FAIL write launch_latency: got %0d want 1", o.lat); end
    n_checks++; if (o.gid != e.core) begin n_fail++; $display("FAIL write grant: got %0d want %0d", o.gid, e.core); end
    n_checks++; if (o.mwv !== 17'h10000 || o.mrv !== '0) begin n_fail++; $display("FAIL write mcu_valid: got w=%h r=%h want w=10000 r=0", o.mwv, o.mrv); end
    n_checks++; if (o.mwa[16] !== 32'h10 || o.mwd[16] !== 32'hDEAD) begin n_fail++; $display("FAIL write addr_data: got %h/%h want 10/dead", o.mwa[16], o.mwd[16]); end
    n_checks++; if (!o.pulse_ok || o.busy_at_launch !== 1'b1) begin n_fail++; $display("FAIL write pulse: got pulse_ok=%0d busy=%b want 1/1", o.pulse_ok, o.busy_at_launch); end
    n_checks++; if (!o.responded || o.gap != 9) begin n_fail++; $display("FAIL write respond_gap: got %0d want 9", o.gap); end
    n_checks++; if (o.cwr !== xw || o.crr !== '0) begin n_fail++; $display("FAIL write ready: got w=%h r=%h want w=%h r=0", o.cwr, o.crr, xw); end
    n_checks++; if (!o.strobe_ok) begin n_fail++; $display("FAIL write strobe_len: got >1 cycle want 1"); end
  endtask

  task automatic test_read();
    exp_t e; obs_t o; logic [NC-1:0][T:0] xr;
    e = make_exp(1, 17'h0000F, '0, 32'h20, 32'h0);
    post_req(e); exp_q.push_back(e);
    observe(1'b1, o);
    e = exp_q.pop_front();
    xr = '0; xr[e.core] = e.rmask;
    n_checks++; if (o.gid != e.core || o.mrv !== e.rmask) begin n_fail++; $display("FAIL read launch: got core %0d mask %h want %0d %h", o.gid, o.mrv, e.core, e.rmask); end
    n_checks++; if (o.mra[3] !== 32'h23) begin n_fail++; $display("FAIL read addr3: got %h want 23", o.mra[3]); end
    n_checks++; if (!o.responded || o.crr !== xr || o.cwr !== '0) begin n_fail++; $display("FAIL read ready: got r=%h w=%h want r=%h w=0", o.crr, o.cwr, xr); end
    for (int l = 0; l < 4; l++) begin
      n_checks++; if (o.crd[l] !== e.rdata[l]) begin n_fail++; $display("FAIL read data lane%0d: got %h want %h", l, o.crd[l], e.rdata[l]); end
    end
  endtask

  task automatic test_rw_same_lane();
    exp_t e; obs_t o;
    e = make_exp(0, 17'h00020, 17'h00020, 32'h30 - 32'd5, 32'h500);
    post_req(e); exp_q.push_back(e);
    observe(1'b1, o);
    e = exp_q.pop_front();
    n_checks++; if (o.mrv !== e.rmask || o.mwv !== e.wmask) begin n_fail++; $display("FAIL rw mcu_valid: got r=%h w=%h want both %h", o.mrv, o.mwv, e.rmask); end
    n_checks++; if (!o.responded || o.crr[0] !== e.rmask || o.cwr[0] !== e.wmask) begin n_fail++; $display("FAIL rw ready: got r=%h w=%h want both %h", o.crr[0], o.cwr[0], e.rmask); end
  endtask

  task automatic test_mask_latch();
    exp_t e; obs_t o;
    e = make_exp(3, 17'h00003, '0, 32'h40, 32'h0);
    post_req(e); exp_q.push_back(e);
    fork
      observe(1'b1, o);
      begin
        repeat (3) @(negedge clk);
        core_read_valid[3] = 17'h00007;
      end
    join
    e = exp_q.pop_front();
    n_checks++; if (!o.responded || o.crr[3] !== e.rmask) begin n_fail++; $display("FAIL mask_latch ready: got %h want %h", o.crr[3], e.rmask); end
  endtask

  task automatic test_ext_busy();
    exp_t e; obs_t o; int early;
    ext_busy = 1'b1;
    e = make_exp(3, '0, 17'h00001, 32'h60, 32'h77);
    post_req(e); exp_q.push_back(e);
    early = 0;
    repeat (10) begin
      @(negedge clk);
      if (arb_busy !== 1'b0 || mcu_write_valid !== '0) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL ext_busy blocked: got %0d active cycles want 0", early); end
    ext_busy = 1'b0;
    observe(1'b1, o);
    e = exp_q.pop_front();
    n_checks++; if (!o.launched || o.gid != e.core || o.lat != 1) begin n_fail++; $display("FAIL ext_busy grant: got core %0d lat %0d want %0d lat 1", o.gid, o.lat, e.core); end
    n_checks++; if (!o.responded || o.cwr[3] !== e.wmask) begin n_fail++; $display("FAIL ext_busy ready: got %h want %h", o.cwr[3], e.wmask); end
  endtask

  task automatic test_fairness();
    exp_t e; obs_t o; logic [NC-1:0][T:0] xr;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < NC; c++) post_req(make_exp(c, 17'(1) << c, 17'(1) << (c + 8), 32'h100 * c, 32'h1000 * c));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) exp_q.push_back(make_exp(c, 17'(1) << c, 17'(1) << (c + 8), 32'h100 * c, 32'h1000 * c));
    for (int n = 0; n < 2 * NC; n++) begin
      observe(1'b0, o);
      e = exp_q.pop_front();
      xr = '0; xr[e.core] = e.rmask;
      n_checks++; if (!o.responded || o.gid != e.core || o.lat != 1) begin n_fail++; $display("FAIL fairness grant%0d: got core %0d lat %0d want core %0d lat 1", n, o.gid, o.lat, e.core); end
      n_checks++; if (o.crr !== xr) begin n_fail++; $display("FAIL fairness ready%0d: got %h want %h", n, o.crr, xr); end
    end
    core_read_valid = '0;
    core_write_valid = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL fairness drained: got busy %b want 0", arb_busy); end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o; bit seen; int strobes;
    e = make_exp(1, 17'h00004, '0, 32'h50, 32'h0);
    post_req(e); exp_q.push_back(e);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mcu_read_valid != '0) begin seen = 1; break; end
    end
    e = exp_q.pop_front();
    n_checks++; if (!seen || int'(arb_grant_id) != e.core) begin n_fail++; $display("FAIL reset_mid launch: got seen=%0d core %0d want core %0d", seen, arb_grant_id, e.core); end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (arb_busy !== 1'b0 || core_read_ready !== '0) begin n_fail++; $display("FAIL reset_mid abort: got busy %b ready %h want 0/0", arb_busy, core_read_ready); end
    core_read_valid[1] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    repeat (12) begin
      @(negedge clk);
      if (core_read_ready != '0 || core_write_ready != '0 || arb_busy) strobes++;
    end
    n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL reset_mid no_strobe: got %0d active cycles want 0", strobes); end
    e = make_exp(2, 17'h00001, '0, 32'h90, 32'h0); post_req(e);
    e = make_exp(0, 17'h00001, '0, 32'h80, 32'h0); post_req(e);
    exp_q.push_back(make_exp(0, 17'h00001, '0, 32'h80, 32'h0));
    exp_q.push_back(make_exp(2, 17'h00001, '0, 32'h90, 32'h0));
    for (int n = 0; n < 2; n++) begin
      observe(1'b1, o);
      e = exp_q.pop_front();
      n_checks++; if (!o.responded || o.gid != e.core || o.crd[0] !== e.rdata[0]) begin n_fail++; $display("FAIL reset_mid regrant%0d: got core %0d data %h want core %0d data %h", n, o.gid, o.crd[0], e.core, e.rdata[0]); end
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < L; l++) begin
        core_read_address[c][l]  = '0;
        core_write_address[c][l] = '0;
        core_write_data[c][l]    = '0;
      end
    test_reset();
    test_single_write();
    test_read();
    test_rw_same_lane();
    test_mask_latch();
    test_ext_busy();
    test_fairness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
